// File: rtl/loss_parent_fwd.sv
// Forward-pass MSE loss: L = (1/N) * sum (H-Y)^2 over one batch.
// Ports: clk/rst, start+N+1/N, H/Y/valid stream; loss_out/valid, busy, overflow.
module loss_parent_fwd #(
  parameter int WIDTH     = 16,
  parameter int FRAC      = 8,
  parameter int ACC_WIDTH = 48,
  parameter int MAX_BATCH = 256,
  localparam int CNT_W    = $clog2(MAX_BATCH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] batch_size_in,
  input  logic [WIDTH-1:0] inv_batch_size_in,
  input  logic [WIDTH-1:0] H_in,
  input  logic [WIDTH-1:0] Y_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] loss_out,
  output logic             loss_valid,
  output logic             busy,
  output logic             overflow
);

  localparam int MAG_W = WIDTH + 1;
  localparam int SQ_W  = 2 * WIDTH + 2;
  localparam int P_W   = ACC_WIDTH + WIDTH;
  localparam int R_W   = P_W - 2 * FRAC;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAXN = CNT_W'(MAX_BATCH);
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  logic [1:0]           state;
  logic [CNT_W-1:0]     n_reg;
  logic [CNT_W-1:0]     count;
  logic [WIDTH-1:0]     inv_reg;
  logic [ACC_WIDTH-1:0] acc;

  logic signed [WIDTH:0] diff;
  logic [MAG_W-1:0]      mag;
  logic [SQ_W-1:0]       sq;
  logic [ACC_WIDTH:0]    sum;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  acc_clamp;
  logic [P_W-1:0]        p;
  logic [R_W-1:0]        r;
  logic                  r_sat;
  logic                  take_start;
  logic                  take_sample;
  logic                  last;

  // Sign-extend to WIDTH+1 so the difference can never wrap.
  assign diff = $signed({H_in[WIDTH-1], H_in})
              - $signed({Y_in[WIDTH-1], Y_in});
  assign mag  = diff[WIDTH] ? MAG_W'(-diff) : MAG_W'(diff);
  assign sq   = {{(SQ_W-MAG_W){1'b0}}, mag}
              * {{(SQ_W-MAG_W){1'b0}}, mag};

  assign sum = {1'b0, acc}
             + {{(ACC_WIDTH+1-SQ_W){1'b0}}, sq};
  assign acc_clamp = sum[ACC_WIDTH];
  assign acc_next  = acc_clamp ? '1 : sum[ACC_WIDTH-1:0];

  // Product carries 3*FRAC fraction bits; drop 2*FRAC to land on Q.FRAC.
  assign p     = {{WIDTH{1'b0}}, acc} * {{ACC_WIDTH{1'b0}}, inv_reg};
  assign r     = R_W'(p >> (2 * FRAC));
  assign r_sat = |r[R_W-1:WIDTH-1];

  assign take_start = (state == IDLE) && start
                   && (batch_size_in != '0)
                   && (batch_size_in <= MAXN);
  assign take_sample = (state == ACCUM) && valid_in;
  assign last        = (count + ONE) == n_reg;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      n_reg      <= '0;
      count      <= '0;
      inv_reg    <= '0;
      acc        <= '0;
      loss_out   <= '0;
      loss_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      loss_valid <= 1'b0;
      unique case (1'b1)
        take_start: begin
          n_reg    <= batch_size_in;
          inv_reg  <= inv_batch_size_in;
          acc      <= '0;
          count    <= '0;
          overflow <= 1'b0;
          state    <= ACCUM;
        end
        take_sample: begin
          acc   <= acc_next;
          count <= count + ONE;
          if (acc_clamp) overflow <= 1'b1;
          if (last) state <= SCALE;
        end
        (state == SCALE): begin
          loss_out   <= r_sat ? POS_MAX : r[WIDTH-1:0];
          if (r_sat) overflow <= 1'b1;
          loss_valid <= 1'b1;
          state      <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_loss_parent_fwd.sv
// Directed bench for loss_parent_fwd.
// Linear step sequence with immediate-assertion checks.
module tb_loss_parent_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  batch_size_in;
  logic [15:0] inv_batch_size_in;
  logic [15:0] H_in;
  logic [15:0] Y_in;
  logic        valid_in;
  logic [15:0] loss_out;
  logic        loss_valid;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  bit got;

  loss_parent_fwd dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .batch_size_in(batch_size_in),
    .inv_batch_size_in(inv_batch_size_in),
    .H_in(H_in),
    .Y_in(Y_in),
    .valid_in(valid_in),
    .loss_out(loss_out),
    .loss_valid(loss_valid),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (loss_valid === 1'b1) pulses++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [8:0] n,
                          input logic [15:0] inv);
    start = 1'b1;
    batch_size_in = n;
    inv_batch_size_in = inv;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic [15:0] h,
                        input logic [15:0] y);
    valid_in = 1'b1;
    H_in = h;
    Y_in = y;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (loss_valid === 1'b1) seen = 1'b1;
      else tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    batch_size_in = '0;
    inv_batch_size_in = '0;
    H_in = '0;
    Y_in = '0;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_loss", 32'(loss_out), 32'h0);
    chk("rst_valid", 32'(loss_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    tick();

    // 1: constant diff 2.0, N=4; valid_in in start cycle must be ignored
    valid_in = 1'b1;
    H_in = 16'h7FFF;
    Y_in = 16'h8000;
    do_start(9'd4, 16'h0040);
    valid_in = 1'b0;
    chk("t1_busy_rise", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) sample(16'h0300, 16'h0100);
    chk("t1_no_early_valid", 32'(loss_valid), 32'h0);
    chk("t1_busy_scale", 32'(busy), 32'h1);
    tick();
    chk("t1_valid", 32'(loss_valid), 32'h1);
    chk("t1_loss", 32'(loss_out), 32'h0400);
    chk("t1_ovf", 32'(overflow), 32'h0);
    chk("t1_busy_done", 32'(busy), 32'h0);
    tick();
    chk("t1_pulse_end", 32'(loss_valid), 32'h0);
    chk("t1_hold", 32'(loss_out), 32'h0400);
    chk("t1_pulses", 32'(pulses), 32'd1);

    // 2: diffs 1.0, -1.0, 0 with gaps; 2.0 * 0x55 >> 8 = 0xAA
    do_start(9'd3, 16'h0055);
    sample(16'h0100, 16'h0000);
    idle(2);
    sample(16'h0000, 16'h0100);
    idle(3);
    sample(16'h0200, 16'h0200);
    wait_valid(got);
    chk("t2_valid", 32'(got), 32'h1);
    chk("t2_loss", 32'(loss_out), 32'h00AA);

    // 3: most negative minus most positive; 17-bit diff, saturated output
    do_start(9'd1, 16'h0100);
    sample(16'h8000, 16'h7FFF);
    wait_valid(got);
    chk("t3_valid", 32'(got), 32'h1);
    chk("t3_loss", 32'(loss_out), 32'h7FFF);
    chk("t3_ovf", 32'(overflow), 32'h1);
    tick();
    chk("t3_ovf_sticky", 32'(overflow), 32'h1);

    // 4: illegal N ignored in IDLE; start ignored in ACCUM
    do_start(9'd0, 16'h0100);
    chk("t4_n0_busy", 32'(busy), 32'h0);
    do_start(9'd257, 16'h0100);
    chk("t4_n257_busy", 32'(busy), 32'h0);
    chk("t4_ign_ovf", 32'(overflow), 32'h1);
    chk("t4_ign_loss", 32'(loss_out), 32'h7FFF);
    do_start(9'd2, 16'h0080);
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_ovf_clr", 32'(overflow), 32'h0);
    sample(16'h0200, 16'h0000);
    do_start(9'd1, 16'h0010);
    chk("t4_mid_busy", 32'(busy), 32'h1);
    sample(16'h0200, 16'h0000);
    wait_valid(got);
    chk("t4_valid", 32'(got), 32'h1);
    chk("t4_loss", 32'(loss_out), 32'h0400);

    // 5: reset mid-batch aborts it, then a fresh batch (0x7F8000 >> 16)
    tick();
    do_start(9'd4, 16'h0040);
    sample(16'h0300, 16'h0100);
    sample(16'h0300, 16'h0100);
    p0 = pulses;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_loss", 32'(loss_out), 32'h0);
    idle(8);
    chk("t5_no_pulse", 32'(pulses), 32'(p0));
    do_start(9'd3, 16'h0055);
    sample(16'h0100, 16'h0000);
    sample(16'h0080, 16'h0000);
    sample(16'h0000, 16'h0080);
    wait_valid(got);
    chk("t5_valid", 32'(got), 32'h1);
    chk("t5_loss", 32'(loss_out), 32'h007F);

    // 6: start while loss_valid is high; diffs 1.0, -3.0 -> 5.0
    do_start(9'd2, 16'h0080);
    chk("t6_busy", 32'(busy), 32'h1);
    sample(16'h0100, 16'h0000);
    sample(16'h0000, 16'h0300);
    wait_valid(got);
    chk("t6_valid", 32'(got), 32'h1);
    chk("t6_loss", 32'(loss_out), 32'h0500);
    chk("t6_ovf", 32'(overflow), 32'h0);
    tick();
    chk("total_pulses", 32'(pulses), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
